tx_link_sched: RTL

TX_LINK_SCHED -- requirements
Module: tx_link_sched

---
 rtl/tx_link_sched.sv | 108 ++++++++++
 1 files changed

// File: rtl/tx_link_sched.sv
// Two-channel 8b10b frame scheduler: comma sync, round-robin grant,
// SOF/HDR/payload/EOF framing paced by the serializer's symbol strobe.
module tx_link_sched #(
  parameter int SYNC_LEN = 4,
  parameter int MAX_LEN  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  req0_data_i,
  input  logic        req0_valid_i,
  input  logic        req0_last_i,
  output logic        req0_ready_o,
  input  logic [7:0]  req1_data_i,
  input  logic        req1_valid_i,
  input  logic        req1_last_i,
  output logic        req1_ready_o,
  input  logic        sym_ena_i,
  output logic [8:0]  sym_o,
  output logic        grant_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [8:0] COMMA = 9'h1BC;
  localparam logic [8:0] SOF   = 9'h1FB;
  localparam logic [8:0] EOF   = 9'h1FD;

  typedef enum logic [2:0] {
    S_SYNC,
    S_IDLE,
    S_HDR,
    S_PAY,
    S_EOF
  } state_t;

  state_t      state;
  logic [3:0]  sync_cnt;
  logic [7:0]  len_cnt;
  logic [8:0]  sym_q;
  logic        grant_q;
  logic [15:0] frame_cnt;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;

  assign g_valid = grant_q ? req1_valid_i : req0_valid_i;
  assign g_last  = grant_q ? req1_last_i  : req0_last_i;
  assign g_data  = grant_q ? req1_data_i  : req0_data_i;

  assign req0_ready_o = sym_ena_i & (state == S_PAY) & ~grant_q & req0_valid_i;
  assign req1_ready_o = sym_ena_i & (state == S_PAY) &  grant_q & req1_valid_i;

  assign sym_o       = sym_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state == S_HDR) | (state == S_PAY) | (state == S_EOF);
  assign frame_cnt_o = frame_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_SYNC;
      sync_cnt  <= '0;
      len_cnt   <= '0;
      sym_q     <= COMMA;
      grant_q   <= 1'b1;
      frame_cnt <= '0;
    end else if (sym_ena_i) begin
      unique case (state)
        S_SYNC: begin
          sym_q    <= COMMA;
          sync_cnt <= sync_cnt + 4'd1;
          if (sync_cnt == 4'(SYNC_LEN - 1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (req0_valid_i | req1_valid_i) begin
            // on contention alternate away from the previous owner
            grant_q <= (req0_valid_i & req1_valid_i) ? ~grant_q : req1_valid_i;
            sym_q   <= SOF;
            state   <= S_HDR;
          end else begin
            sym_q <= COMMA;
          end
        end
        S_HDR: begin
          sym_q   <= {8'd0, grant_q};
          len_cnt <= '0;
          state   <= S_PAY;
        end
        S_PAY: begin
          if (g_valid) begin
            sym_q   <= {1'b0, g_data};
            len_cnt <= len_cnt + 8'd1;
            if (g_last || len_cnt == 8'(MAX_LEN - 1)) state <= S_EOF;
          end else begin
            sym_q <= COMMA;
          end
        end
        S_EOF: begin
          sym_q     <= EOF;
          frame_cnt <= frame_cnt + 16'd1;
          state     <= S_IDLE;
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule
